// File: rtl/rib_timer.sv
// RIB-bus timer responder: prescaled 32-bit up-counter with compare match,
// write-1-to-clear pending flag and registered level interrupt.
module rib_timer #(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        int_sig_o
);

    localparam logic [PRESCALE_W-1:0] PSC_ONE = 1;

    logic                  en_q, en_d;
    logic                  int_en_q, int_en_d;
    logic                  pend_q, pend_d;
    logic                  auto_rl_q, auto_rl_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           compare_q, compare_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] psc_cnt_q, psc_cnt_d;
    logic                  int_sig_q, int_sig_d;

    logic       wr_en;
    logic [1:0] sel;
    logic       tick;
    logic       match;
    logic       unused_addr;

    assign wr_en       = req_i & we_i;
    assign sel         = addr_i[3:2];
    assign tick        = en_q && (psc_cnt_q == prescale_q);
    assign match       = tick && (count_q == compare_q);
    assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};

    always_comb begin
        en_d       = en_q;
        int_en_d   = int_en_q;
        pend_d     = pend_q;
        auto_rl_d  = auto_rl_q;
        count_d    = count_q;
        compare_d  = compare_q;
        prescale_d = prescale_q;
        psc_cnt_d  = psc_cnt_q;

        if (en_q) begin
            psc_cnt_d = tick ? '0 : psc_cnt_q + PSC_ONE;
        end
        if (tick) begin
            count_d = (match && auto_rl_q) ? 32'd0 : count_q + 32'd1;
        end

        // Software writes override the tick update; the match above used pre-write state.
        if (wr_en) begin
            case (sel)
                2'd0: begin
                    en_d      = data_i[0];
                    int_en_d  = data_i[1];
                    auto_rl_d = data_i[3];
                    if (data_i[2]) begin
                        pend_d = 1'b0;
                    end
                end
                2'd1: count_d = data_i;
                2'd2: compare_d = data_i;
                default: begin
                    prescale_d = data_i[PRESCALE_W-1:0];
                    psc_cnt_d  = '0;
                end
            endcase
        end

        // A match on the same edge as a clear wins.
        if (match) begin
            pend_d = 1'b1;
        end

        int_sig_d = pend_d & int_en_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q       <= 1'b0;
            int_en_q   <= 1'b0;
            pend_q     <= 1'b0;
            auto_rl_q  <= 1'b0;
            count_q    <= 32'd0;
            compare_q  <= 32'hFFFF_FFFF;
            prescale_q <= '0;
            psc_cnt_q  <= '0;
            int_sig_q  <= 1'b0;
        end else begin
            en_q       <= en_d;
            int_en_q   <= int_en_d;
            pend_q     <= pend_d;
            auto_rl_q  <= auto_rl_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            prescale_q <= prescale_d;
            psc_cnt_q  <= psc_cnt_d;
            int_sig_q  <= int_sig_d;
        end
    end

    always_comb begin
        data_o = '0;
        if (req_i && !we_i) begin
            case (sel)
                2'd0:    data_o = {28'd0, auto_rl_q, pend_q, int_en_q, en_q};
                2'd1:    data_o = count_q;
                2'd2:    data_o = compare_q;
                default: data_o[PRESCALE_W-1:0] = prescale_q;
            endcase
        end
    end

    assign int_sig_o = int_sig_q;

endmodule

// File: tb/tb_rib_timer.sv
// Self-checking bench for rib_timer: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_rib_timer;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        int_sig_o;

    int n_tests = 0;
    int n_fail  = 0;

    rib_timer #(.PRESCALE_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .int_sig_o (int_sig_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: m_wait counts enabled cycles left before the next tick.
    logic        m_en, m_int_en, m_pend, m_auto, m_int;
    logic [31:0] m_count, m_cmp;
    int          m_psc;
    int          m_wait;

    function automatic logic [31:0] model_read(logic q, logic w, logic [31:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (q && !w) begin
            case (a[3:2])
                2'd0: r = {28'd0, m_auto, m_pend, m_int_en, m_en};
                2'd1: r = m_count;
                2'd2: r = m_cmp;
                default: r = 32'(m_psc);
            endcase
        end
        return r;
    endfunction

    task automatic model_step(input logic r, q, w, input logic [31:0] a, d);
        logic        tick, hit, n_pend, n_int_en;
        logic [31:0] n_count;
        int          n_wait;
        if (r) begin
            m_en = 0; m_int_en = 0; m_pend = 0; m_auto = 0;
            m_count = 0; m_cmp = 32'hFFFF_FFFF; m_psc = 0; m_wait = 0; m_int = 0;
            return;
        end
        tick     = m_en && (m_wait == 0);
        hit      = tick && (m_count == m_cmp);
        n_count  = m_count;
        n_wait   = m_wait;
        n_pend   = m_pend;
        n_int_en = m_int_en;
        if (tick) n_count = (hit && m_auto) ? 32'd0 : m_count + 32'd1;
        if (m_en) n_wait = tick ? m_psc : m_wait - 1;
        if (q && w) begin
            case (a[3:2])
                2'd0: begin
                    m_en = d[0]; n_int_en = d[1]; m_auto = d[3];
                    if (d[2]) n_pend = 0;
                end
                2'd1: n_count = d;
                2'd2: m_cmp = d;
                default: begin
                    m_psc  = int'(d & 32'h0000_FFFF);
                    n_wait = m_psc;
                end
            endcase
        end
        if (hit) n_pend = 1;
        m_count  = n_count;
        m_wait   = n_wait;
        m_pend   = n_pend;
        m_int_en = n_int_en;
        m_int    = n_pend & n_int_en;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One bus cycle: drive, sample data_o mid-cycle, then sample int_sig_o just after the edge.
    task automatic cyc(input logic r, q, w, input logic [31:0] a, d,
                       output logic [31:0] got_d, output logic got_i);
        rst = r; req_i = q; we_i = w; addr_i = a; data_i = d;
        #2;
        got_d = data_o;
        check("model_data_o", got_d, model_read(q, w, a));
        @(posedge clk);
        model_step(r, q, w, a, d);
        #1;
        got_i = int_sig_o;
        check("model_int_sig_o", {31'd0, got_i}, {31'd0, m_int});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] gd; logic gi;
        cyc(1'b0, 1'b1, 1'b1, a, d, gd, gi);
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        logic [31:0] gd; logic gi;
        cyc(1'b0, 1'b1, 1'b0, a, 32'd0, gd, gi);
        check(name, gd, exp);
    endtask

    task automatic idle(input int n);
        logic [31:0] gd; logic gi;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, gd, gi);
    endtask

    task automatic do_reset();
        logic [31:0] gd; logic gi;
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, gd, gi);
    endtask

    task automatic wr_int_chk(input logic [31:0] a, input logic [31:0] d,
                              input logic exp, input string name);
        logic [31:0] gd; logic gi;
        cyc(1'b0, 1'b1, 1'b1, a, d, gd, gi);
        check(name, {31'd0, gi}, {31'd0, exp});
    endtask

    typedef struct {
        logic        r, q, w;
        logic [31:0] a, d, exp_d;
        logic        exp_i;
    } vec_t;

    vec_t vt[15];

    initial begin
        logic [31:0] gd;
        logic        gi;
        logic        r, q, w;
        logic [31:0] a, d;

        rst = 1'b1; req_i = 0; we_i = 0; addr_i = 0; data_i = 0;
        m_en = 0; m_int_en = 0; m_pend = 0; m_auto = 0; m_int = 0;
        m_count = 0; m_cmp = 32'hFFFF_FFFF; m_psc = 0; m_wait = 0;

        vt[0]  = '{1, 0, 0, 32'h0,        32'h0,         32'h0,         0};
        vt[1]  = '{0, 1, 0, 32'h0,        32'h0,         32'h0,         0};
        vt[2]  = '{0, 1, 0, 32'h4,        32'h0,         32'h0,         0};
        vt[3]  = '{0, 1, 0, 32'h8,        32'h0,         32'hFFFF_FFFF, 0};
        vt[4]  = '{0, 1, 0, 32'hC,        32'h0,         32'h0,         0};
        vt[5]  = '{0, 1, 1, 32'h8,        32'hA5A5_A5A5, 32'h0,         0};
        vt[6]  = '{0, 1, 0, 32'h8,        32'h0,         32'hA5A5_A5A5, 0};
        vt[7]  = '{0, 1, 1, 32'h0,        32'hFFFF_FFFF, 32'h0,         0};
        vt[8]  = '{0, 1, 0, 32'h0,        32'h0,         32'h0000_000B, 0};
        vt[9]  = '{0, 1, 0, 32'hFFFF_FFF1, 32'h0,        32'h0000_000B, 0};
        vt[10] = '{0, 1, 0, 32'hE,        32'h0,         32'h0,         0};
        vt[11] = '{0, 0, 1, 32'h8,        32'h0,         32'h0,         0};
        vt[12] = '{0, 1, 0, 32'h8,        32'h0,         32'hA5A5_A5A5, 0};
        vt[13] = '{0, 1, 1, 32'hC,        32'hFFFF_1234, 32'h0,         0};
        vt[14] = '{0, 1, 0, 32'hC,        32'h0,         32'h0000_1234, 0};

        for (int i = 0; i < 15; i++) begin
            cyc(vt[i].r, vt[i].q, vt[i].w, vt[i].a, vt[i].d, gd, gi);
            check($sformatf("vec%0d_data", i), gd, vt[i].exp_d);
            check($sformatf("vec%0d_int", i), {31'd0, gi}, {31'd0, vt[i].exp_i});
        end

        // Prescale: tick every 4 enabled cycles, freeze when disabled.
        do_reset();
        wr(32'hC, 32'd3);
        wr(32'h0, 32'h1);
        idle(4);
        rd_chk(32'h4, 32'd1, "psc_count_after_4");
        idle(15);
        rd_chk(32'h4, 32'd5, "psc_count_after_20");
        wr(32'h0, 32'h0);
        idle(8);
        rd_chk(32'h4, 32'd5, "psc_count_frozen");

        // Match with auto-reload, then write-1-to-clear drops the interrupt.
        do_reset();
        wr(32'hC, 32'd0);
        wr(32'h8, 32'd5);
        wr(32'h0, 32'hB);
        idle(5);
        cyc(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, gd, gi);
        check("match_count_pre", gd, 32'd5);
        check("match_int_rise", {31'd0, gi}, 32'd1);
        rd_chk(32'h4, 32'd0, "match_autoreload_count");
        wr_int_chk(32'h0, 32'hF, 1'b0, "clear_pend_int_fall");

        // Wrap past 0xFFFFFFFF without a match.
        do_reset();
        wr(32'h8, 32'h10);
        wr(32'h4, 32'hFFFF_FFFE);
        wr(32'h0, 32'h1);
        idle(2);
        rd_chk(32'h4, 32'd0, "wrap_count");
        rd_chk(32'h0, 32'h1, "wrap_no_pend");

        // Collisions: COUNT write on a match edge, then clear-vs-set on a match edge.
        do_reset();
        wr(32'h8, 32'd3);
        wr(32'h0, 32'h1);
        idle(3);
        wr(32'h4, 32'h100);
        rd_chk(32'h4, 32'h100, "coll_count_write_wins");
        rd_chk(32'h0, 32'h5, "coll_pend_set");
        wr(32'h0, 32'h0);
        rd_chk(32'h4, 32'h103, "coll_tick_on_disable_edge");
        wr(32'h4, 32'h20);
        wr(32'h8, 32'h20);
        wr(32'h0, 32'h5);
        wr(32'h0, 32'h5);
        rd_chk(32'h0, 32'h5, "coll_set_beats_clear");
        rd_chk(32'h4, 32'h22, "coll_count_after_match");

        // Enabling the interrupt with pend already set raises it on the write edge.
        wr_int_chk(32'h0, 32'h3, 1'b1, "int_en_rise");

        // Mid-operation reset beats a concurrent COUNT write.
        cyc(1'b1, 1'b1, 1'b1, 32'h4, 32'h55, gd, gi);
        check("rst_int_low", {31'd0, gi}, 32'd0);
        rd_chk(32'h0, 32'h0, "rst_ctrl");
        rd_chk(32'h4, 32'h0, "rst_count");
        rd_chk(32'h8, 32'hFFFF_FFFF, "rst_compare");
        rd_chk(32'hC, 32'h0, "rst_prescale");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            q = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1);
            a = $urandom;
            case (a[3:2])
                2'd0: d = $urandom;
                2'd1: d = $urandom_range(0, 1) ? m_cmp - $urandom_range(0, 6) : $urandom;
                2'd2: d = $urandom_range(0, 3) != 0 ? m_count + $urandom_range(0, 8) : $urandom;
                default: d = {$urandom_range(0, 65535), 16'(0)} | $urandom_range(0, 3);
            endcase
            cyc(r, q, w, a, d, gd, gi);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rib_timer.md
# rib_timer

Memory-mapped timer that acts as a responder on the core's RIB data bus. It decodes read and write requests from the core's execute-stage bus master and returns read data in the same cycle. It runs a prescaled 32-bit up-counter with a compare match, and raises a level interrupt that feeds one bit of the core's `int_i` bus. The interconnect performs base-address selection; this block sees only its own requests.

## Interface

**Parameters**

- `PRESCALE_W`, default 16: width of the prescaler register and its counter.

**Ports**

- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `req_i` in 1: access request; the block is selected this cycle.
- `we_i` in 1: 1 = write, 0 = read; valid only with `req_i`.
- `addr_i` in 32: byte address; only `addr_i[3:2]` is decoded.
- `data_i` in 32: write data.
- `data_o` out 32: read data, combinational.
- `int_sig_o` out 1: interrupt, level, registered.

## Operation

**Register map** (word index is `addr_i[3:2]`; `addr_i[1:0]` and `addr_i[31:4]` are ignored):

- 0 CTRL:
  - bit0 `en`: counting enabled.
  - bit1 `int_en`: interrupt enabled.
  - bit2 `pend`: match pending. Read returns the flag. Writing 1 clears it; writing 0 leaves it unchanged.
  - bit3 `auto_rl`: clear COUNT on match.
  - bits 31:4 read 0.
- 1 COUNT: 32-bit, read/write.
- 2 COMPARE: 32-bit, read/write.
- 3 PRESCALE: low `PRESCALE_W` bits read/write; upper bits read 0.

**Reads**

- `data_o` is the selected register when `req_i & ~we_i`.
- `data_o` is 0 otherwise.
- Reads have no side effects.

**Writes**

- A write is committed on the rising `clk` edge where `req_i & we_i`.

**Prescaler** (`psc_cnt`, `PRESCALE_W` bits, internal)

- While `en` = 0: `psc_cnt` holds and no ticks occur.
- While `en` = 1: when `psc_cnt == PRESCALE`, set `psc_cnt <= 0` and assert internal `tick` that cycle; otherwise `psc_cnt <= psc_cnt + 1`.
- PRESCALE = 0 gives a tick every cycle.
- Writing PRESCALE resets `psc_cnt` to 0 on the same edge.

**Counter on tick**

- If COUNT == COMPARE: set `pend <= 1`. COUNT becomes 0 if `auto_rl`, else COUNT+1.
- Otherwise COUNT <= COUNT+1, wrapping mod 2^32 (0xFFFFFFFF → 0, no flag).

**Interrupt**

- `int_sig_o <= pend_next & int_en_next`, registered, so it reflects state after the current edge.

**Simultaneous events (priority)**

- A software write to COUNT overrides the tick update of COUNT. The match check still uses the pre-write COUNT, so `pend` may still set.
- When a match set and a CTRL write-1-to-clear of `pend` occur on the same edge, the set wins: `pend` stays 1.
- A CTRL write that clears `en` in a cycle that would tick: the tick still applies on that edge, since the `en` value before the edge governs.

**Reset**

- On the edge with `rst` = 1: CTRL = 0, COUNT = 0, COMPARE = 0xFFFFFFFF, PRESCALE = 0, `psc_cnt` = 0, `int_sig_o` = 0.
- `rst` overrides any concurrent write.
- `data_o` is combinational, so it is 0 unless a read is requested during reset. A read during reset returns the reset values after the edge.

## Timing

- Read latency is 0 cycles: `data_o` is valid in the same cycle as `req_i`. This matches the core's same-cycle load datapath, and the block never stalls the bus (no hold output).
- Write latency is 1 edge: the new value is visible to a read in the next cycle.
- Tick period is PRESCALE+1 cycles.
- Interrupt: `pend` and `int_sig_o` go high on the same edge as the matching tick.
- Clearing `pend`: `int_sig_o` falls on the write edge.
- Setting `int_en` while `pend` = 1: `int_sig_o` rises on the write edge.
- Critical path: the 32-bit equality compare plus increment; the 4:1 read mux is combinational from `addr_i`.

## Test plan

- **Reset/readback.** After `rst`, read words 0–3 → 0, 0, 0xFFFFFFFF, 0. Write 0xA5A5A5A5 to COMPARE, then read → 0xA5A5A5A5. Write 0xFFFFFFFF to CTRL, then read → 0x0000000B (`pend` not set by write).
- **Prescale.** PRESCALE = 3, CTRL = 1. COUNT reads 1 after 4 cycles and 5 after 20 cycles. Clear `en`: COUNT freezes.
- **Match + auto-reload.** PRESCALE = 0, COMPARE = 5, CTRL = 0xB. On the edge where COUNT is 5: COUNT → 0 and `int_sig_o` → 1. Then write CTRL = 0xF: `int_sig_o` → 0 on the next edge.
- **Wrap.** COUNT = 0xFFFFFFFE, COMPARE = 0x10, CTRL = 1, PRESCALE = 0. After 2 cycles COUNT reads 0 and `pend` reads 0.
- **Collisions.**
  - Write COUNT = 0x100 on a tick edge with COUNT == COMPARE: COUNT reads 0x100 and `pend` reads 1.
  - Write CTRL with bit2 = 1 on a match edge: `pend` remains 1.
- **Mid-operation reset.** Assert `rst` for 1 cycle while counting with `pend` = 1, together with a write to COUNT: all registers take their reset values and `int_sig_o` = 0 the next cycle.
